sram_req_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage).
- Grants one request per cycle and records the source of every accepted request in an in-order tag queue, so each data_ok is routed back to the correct requester.
- Sits between the pipeline stages and the memory bridge; it is the single point that sequences fetch versus load/store traffic.

---
 rtl/sram_req_arbiter.sv | 95 +++++++++
 tb/tb_sram_req_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one SRAM-like port between IF and MEM requesters with an in-order source-tag queue.
// Define ARB_RR_EN for round-robin grant; otherwise data has fixed priority over inst.
module sram_req_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [3:0]        m_wstrb,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [31:0]       m_rdata,
  output logic              busy
);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic lock_q, lock_d, lsrc_q, lsrc_d;
  logic full, pick, src, push, pop, head;
`ifdef ARB_RR_EN
  logic last_q, last_d;
  assign pick   = (data_req & inst_req) ? ~last_q : data_req;
  assign last_d = push ? src : last_q;
  always_ff @(posedge clk)
    last_q <= reset ? 1'b1 : last_d;
`else
  assign pick = data_req;
`endif
  // full gating uses registered count, so a pop frees a slot only from the next cycle
  assign full  = cnt_q == CW'(MAX_OUTSTANDING);
  assign src   = lock_q ? lsrc_q : pick;
  assign m_req = ~reset & ~full & (lock_q | inst_req | data_req);
  assign push  = m_req & m_addr_ok;
  assign pop   = ~reset & m_data_ok & (cnt_q != '0);
  assign head  = tag_q[rd_q];
  assign m_wr    = m_req & src & data_wr;
  assign m_size  = ~m_req ? 2'd0 : src ? data_size : 2'd2;
  assign m_wstrb = (m_req & src) ? data_wstrb : 4'd0;
  assign m_addr  = ~m_req ? '0 : src ? data_addr : inst_addr;
  assign m_wdata = (m_req & src) ? data_wdata : 32'd0;
  assign inst_addr_ok = push & ~src;
  assign data_addr_ok = push & src;
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;
  assign busy         = cnt_q != '0;
  always_comb begin
    tag_d = tag_q;
    if (push) tag_d[wr_q] = src;
    wr_d   = push ? (wr_q == PW'(MAX_OUTSTANDING - 1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d   = pop ? (rd_q == PW'(MAX_OUTSTANDING - 1) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    lock_d = m_req ? ~m_addr_ok : lock_q;
    lsrc_d = (m_req & ~m_addr_ok) ? src : lsrc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      lock_q <= 1'b0;
      lsrc_q <= 1'b0;
    end else begin
      tag_q  <= tag_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
      lsrc_q <= lsrc_d;
    end
  end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter: directed self-checking bench for sram_req_arbiter (default fixed-priority build).
module tb_sram_req_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic inst_req = 0, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr = 0, inst_rdata;
  logic data_req = 0, data_wr = 0, data_addr_ok, data_data_ok;
  logic [1:0] data_size = 0;
  logic [3:0] data_wstrb = 0;
  logic [31:0] data_addr = 0, data_wdata = 0, data_rdata;
  logic m_req, m_wr, m_addr_ok = 0, m_data_ok = 0, busy;
  logic [1:0] m_size;
  logic [3:0] m_wstrb;
  logic [31:0] m_addr, m_wdata, m_rdata = 0;
  int total = 0, bad = 0;

  sram_req_arbiter #(.MAX_OUTSTANDING(2), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ok(input string tag, input logic ia, input logic da, input logic id, input logic dd);
    #1;
    chk({tag, ".inst_addr_ok"}, 32'(inst_addr_ok), 32'(ia));
    chk({tag, ".data_addr_ok"}, 32'(data_addr_ok), 32'(da));
    chk({tag, ".inst_data_ok"}, 32'(inst_data_ok), 32'(id));
    chk({tag, ".data_data_ok"}, 32'(data_data_ok), 32'(dd));
  endtask

  initial begin
    data_size = 2'd2;
    step();
    #1;
    chk("rst.m_req", 32'(m_req), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.m_addr", m_addr, 0);
    ok("rst", 0, 0, 0, 0);
    reset = 0;
    step();
    // single fetch: accepted one cycle late, answered two cycles after accept
    inst_req = 1; inst_addr = 32'h1c000000;
    ok("f1.c0", 0, 0, 0, 0);
    chk("f1.m_req", 32'(m_req), 1);
    chk("f1.m_addr", m_addr, 32'h1c000000);
    chk("f1.m_size", 32'(m_size), 2);
    step();
    m_addr_ok = 1;
    ok("f1.c1", 1, 0, 0, 0);
    step();
    inst_req = 0; m_addr_ok = 0;
    ok("f1.c2", 0, 0, 0, 0);
    chk("f1.busy", 32'(busy), 1);
    chk("f1.m_req_idle", 32'(m_req), 0);
    step();
    m_data_ok = 1; m_rdata = 32'h02800413;
    ok("f1.c3", 0, 0, 1, 0);
    chk("f1.inst_rdata", inst_rdata, 32'h02800413);
    step();
    m_data_ok = 0;
    ok("f1.c4", 0, 0, 0, 0);
    chk("f1.busy_end", 32'(busy), 0);
    // contention: data wins, inst follows
    inst_req = 1; inst_addr = 32'h1c000008;
    data_req = 1; data_wr = 0; data_addr = 32'h1c001000; m_addr_ok = 1;
    ok("ct.c0", 0, 1, 0, 0);
    chk("ct.m_addr0", m_addr, 32'h1c001000);
    step();
    data_req = 0;
    ok("ct.c1", 1, 0, 0, 0);
    chk("ct.m_addr1", m_addr, 32'h1c000008);
    step();
    inst_req = 0; m_addr_ok = 0;
    m_data_ok = 1; m_rdata = 32'hAAAA0000;
    ok("ct.r0", 0, 0, 0, 1);
    chk("ct.data_rdata", data_rdata, 32'hAAAA0000);
    step();
    m_rdata = 32'h5555FFFF;
    ok("ct.r1", 0, 0, 1, 0);
    chk("ct.inst_rdata", inst_rdata, 32'h5555FFFF);
    step();
    m_data_ok = 0;
    chk("ct.busy", 32'(busy), 0);
    // lock: inst granted and stalled, data arrives mid-handshake
    inst_req = 1; inst_addr = 32'h1c000004;
    ok("lk.c0", 0, 0, 0, 0);
    step();
    data_req = 1; data_wr = 1; data_addr = 32'h1c002000; data_wdata = 32'h12345678; data_wstrb = 4'hf;
    ok("lk.c1", 0, 0, 0, 0);
    chk("lk.m_addr1", m_addr, 32'h1c000004);
    chk("lk.m_wr1", 32'(m_wr), 0);
    step();
    ok("lk.c2", 0, 0, 0, 0);
    chk("lk.m_addr2", m_addr, 32'h1c000004);
    step();
    m_addr_ok = 1;
    ok("lk.c3", 1, 0, 0, 0);
    chk("lk.m_addr3", m_addr, 32'h1c000004);
    step();
    inst_req = 0;
    ok("lk.c4", 0, 1, 0, 0);
    chk("lk.m_wr", 32'(m_wr), 1);
    chk("lk.m_wdata", m_wdata, 32'h12345678);
    chk("lk.m_wstrb", 32'(m_wstrb), 32'hf);
    chk("lk.m_addr4", m_addr, 32'h1c002000);
    step();
    data_req = 0; data_wr = 0; m_addr_ok = 0; m_data_ok = 1;
    ok("lk.r0", 0, 0, 1, 0);
    step();
    ok("lk.r1", 0, 0, 0, 1);
    step();
    m_data_ok = 0;
    chk("lk.busy", 32'(busy), 0);
    // full: two fetches fill the queue
    inst_req = 1; inst_addr = 32'h1c000010; m_addr_ok = 1;
    ok("fl.a0", 1, 0, 0, 0);
    step();
    inst_addr = 32'h1c000014;
    ok("fl.a1", 1, 0, 0, 0);
    step();
    inst_addr = 32'h1c000018;
    ok("fl.c0", 0, 0, 0, 0);
    chk("fl.m_req0", 32'(m_req), 0);
    step();
    m_data_ok = 1;
    ok("fl.pop", 0, 0, 1, 0);
    chk("fl.m_req_pop", 32'(m_req), 0);
    step();
    m_data_ok = 0;
    ok("fl.resume", 1, 0, 0, 0);
    chk("fl.m_addr", m_addr, 32'h1c000018);
    step();
    inst_req = 0; m_addr_ok = 0; m_data_ok = 1;
    ok("fl.d0", 0, 0, 1, 0);
    step();
    ok("fl.d1", 0, 0, 1, 0);
    step();
    m_data_ok = 0;
    chk("fl.busy", 32'(busy), 0);
    // simultaneous push and pop with count=1 (head is a data load)
    data_req = 1; data_addr = 32'h1c003000; m_addr_ok = 1;
    ok("pp.a0", 0, 1, 0, 0);
    step();
    data_req = 0; inst_req = 1; inst_addr = 32'h1c00001c; m_data_ok = 1; m_rdata = 32'hdeadbeef;
    ok("pp.both", 1, 0, 0, 1);
    chk("pp.data_rdata", data_rdata, 32'hdeadbeef);
    step();
    inst_req = 0; m_addr_ok = 0; m_data_ok = 0;
    chk("pp.busy", 32'(busy), 1);
    m_data_ok = 1;
    ok("pp.r1", 0, 0, 1, 0);
    step();
    m_data_ok = 0;
    chk("pp.busy_end", 32'(busy), 0);
    // reset with two outstanding, then a stray response
    inst_req = 1; inst_addr = 32'h1c000020; m_addr_ok = 1;
    step();
    step();
    inst_req = 0; m_addr_ok = 0;
    chk("rm.busy_pre", 32'(busy), 1);
    reset = 1;
    step();
    reset = 0;
    #1;
    chk("rm.busy", 32'(busy), 0);
    m_data_ok = 1;
    ok("rm.stray", 0, 0, 0, 0);
    step();
    m_data_ok = 0; inst_req = 1; inst_addr = 32'h1c000024; m_addr_ok = 1;
    ok("rm.a0", 1, 0, 0, 0);
    step();
    inst_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h00000013;
    ok("rm.r0", 0, 0, 1, 0);
    chk("rm.inst_rdata", inst_rdata, 32'h00000013);
    step();
    m_data_ok = 0;
    chk("rm.busy_end", 32'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
